trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 19 +
 rtl/trap_irq_prio.sv | 27 ++
 rtl/trap_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared privilege codes, FSM states, interrupt cause codes and settle length.
package trap_ctrl_pkg;
    localparam logic [1:0] M_MODE = 2'b11;
    localparam logic [1:0] S_MODE = 2'b01;
    localparam logic [1:0] U_MODE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDIR  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_EXT  = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_TIM  = 2'd3;

    localparam logic [1:0] SETTLE_CYCLES = 2'd2;
endpackage

// File: rtl/trap_irq_prio.sv
// trap_irq_prio: masks interrupt sources with their enables and picks the winner.
// Inputs : irq_ext/irq_tim/irq_sw level sources, csr_rmie global enable,
//          csr_meie/csr_mtie/csr_msie per-source enables.
// Outputs: irq_pend (any enabled source), irq_cause (ext > sw > tim, 0 if none).
module trap_irq_prio
    import trap_ctrl_pkg::*;
(
    input  logic       irq_ext,
    input  logic       irq_tim,
    input  logic       irq_sw,
    input  logic       csr_rmie,
    input  logic       csr_meie,
    input  logic       csr_mtie,
    input  logic       csr_msie,
    output logic       irq_pend,
    output logic [1:0] irq_cause
);
    logic pend_ext, pend_tim, pend_sw;

    always_comb begin
        pend_ext  = irq_ext & csr_meie & csr_rmie;
        pend_tim  = irq_tim & csr_mtie & csr_rmie;
        pend_sw   = irq_sw  & csr_msie & csr_rmie;
        irq_pend  = pend_ext | pend_tim | pend_sw;
        irq_cause = pend_ext ? CAUSE_EXT : pend_sw ? CAUSE_SW : pend_tim ? CAUSE_TIM : CAUSE_NONE;
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap/return sequencer; takes exceptions, ecall, mret and interrupts
// from EX, then redirects the PC and holds off new traps for a short settle window.
// Inputs : clk, rst_n (async, active-low), irq_* sources, csr_* enables,
//          illegal_ops_ex/cmd_ecall_ex/cmd_mret_ex commands, inst_valid_ex, stall,
//          csr_mtvec_ex/csr_mepc_ex target addresses.
// Outputs: g_interrupt/g_exception entry strobes, constant M-mode priv outputs,
//          irq_cause, flush_req, jump_req/jump_adr redirect, busy.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        irq_ext,
    input  logic        irq_tim,
    input  logic        irq_sw,
    input  logic        csr_rmie,
    input  logic        csr_meie,
    input  logic        csr_mtie,
    input  logic        csr_msie,
    input  logic        illegal_ops_ex,
    input  logic        cmd_ecall_ex,
    input  logic        cmd_mret_ex,
    input  logic        inst_valid_ex,
    input  logic        stall,
    input  logic [31:2] csr_mtvec_ex,
    input  logic [31:2] csr_mepc_ex,
    output logic        g_interrupt,
    output logic        g_exception,
    output logic [1:0]  g_interrupt_priv,
    output logic [1:0]  g_current_priv,
    output logic [1:0]  irq_cause,
    output logic        flush_req,
    output logic        jump_req,
    output logic [31:2] jump_adr,
    output logic        busy
);
    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:2] adr_q, adr_d;
    logic        irq_pend;
    logic [1:0]  prio_cause;
    logic        take;

    trap_irq_prio u_prio (
        .irq_ext   (irq_ext),
        .irq_tim   (irq_tim),
        .irq_sw    (irq_sw),
        .csr_rmie  (csr_rmie),
        .csr_meie  (csr_meie),
        .csr_mtie  (csr_mtie),
        .csr_msie  (csr_msie),
        .irq_pend  (irq_pend),
        .irq_cause (prio_cause)
    );

    assign g_interrupt_priv = M_MODE;
    assign g_current_priv   = M_MODE;
    assign jump_adr         = adr_q;
    assign busy             = state_q != ST_IDLE;
    // rst_n gates take so the Mealy strobes stay quiet while reset is held.
    assign take             = rst_n & (state_q == ST_IDLE) & ~stall & inst_valid_ex;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        g_interrupt = 1'b0;
        g_exception = 1'b0;
        irq_cause   = CAUSE_NONE;
        flush_req   = 1'b0;
        jump_req    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    if (illegal_ops_ex) begin
                        g_exception = 1'b1;
                        adr_d       = csr_mtvec_ex;
                        state_d     = ST_REDIR;
                    end else if (cmd_ecall_ex) begin
                        adr_d   = csr_mtvec_ex;
                        state_d = ST_REDIR;
                    end else if (cmd_mret_ex) begin
                        adr_d   = csr_mepc_ex;
                        state_d = ST_REDIR;
                    end else if (irq_pend) begin
                        g_interrupt = 1'b1;
                        irq_cause   = prio_cause;
                        adr_d       = csr_mtvec_ex;
                        state_d     = ST_REDIR;
                    end
                end
            end
            ST_REDIR: begin
                flush_req = 1'b1;
                jump_req  = 1'b1;
                cnt_d     = SETTLE_CYCLES;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Leave once the count reaches zero, giving SETTLE_CYCLES masked cycles.
                cnt_d = cnt_q - 2'd1;
                if (cnt_d == 2'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
        end
    end
endmodule
